// File: rtl/carrier_phase_detector_if.sv
// Sample input / phase-error output bundle for the carrier phase detector.
// The master drives baseband samples; the slave returns pd, its strobe and lock status.
interface carrier_phase_detector_if #(
  parameter int WIN_LOG2 = 8
);
  logic                din_valid;
  logic signed [15:0]  di;
  logic signed [15:0]  dq;
  logic signed [25:0]  pd;
  logic                pd_valid;
  logic                locked;
  logic [WIN_LOG2:0]   lock_metric;

  modport master (
    output din_valid, di, dq,
    input  pd, pd_valid, locked, lock_metric
  );

  modport slave (
    input  din_valid, di, dq,
    output pd, pd_valid, locked, lock_metric
  );
endinterface

// File: rtl/carrier_phase_detector.sv
// Decision-directed carrier phase detector: e = sign(I)*Q - sign(Q)*I, scaled onto pd,
// plus a windowed good-sample counter driving an UNLOCKED/CANDIDATE/LOCKED lock FSM.
module carrier_phase_detector #(
  parameter int PD_SHIFT   = 8,
  parameter int WIN_LOG2   = 8,
  parameter int LOCK_TH    = 224,
  parameter int UNLOCK_TH  = 160,
  parameter int LOCK_SHIFT = 2,
  parameter int MIN_AMP    = 256
) (
  input logic                      clk,
  input logic                      rst,
  carrier_phase_detector_if.slave  s
);

  typedef enum logic [1:0] {
    ST_UNLOCKED  = 2'd0,
    ST_CANDIDATE = 2'd1,
    ST_LOCKED    = 2'd2
  } state_t;

  localparam logic [WIN_LOG2:0]   LOCK_TH_C   = LOCK_TH[WIN_LOG2:0];
  localparam logic [WIN_LOG2:0]   UNLOCK_TH_C = UNLOCK_TH[WIN_LOG2:0];
  localparam logic [16:0]         MIN_AMP_C   = MIN_AMP[16:0];
  localparam logic [WIN_LOG2-1:0] WCNT_ONE    = {{(WIN_LOG2-1){1'b0}}, 1'b1};

  logic signed [17:0]  w_i18, w_q18, w_neg_i, w_neg_q, w_t1, w_t2, w_e18;
  logic [16:0]         w_abs_i, w_abs_q, w_amp;
  logic signed [16:0]  w_neg_e;
  logic [16:0]         w_abs_e, w_tol;
  logic                w_good;
  logic signed [25:0]  w_pd_ext;
  logic [WIN_LOG2:0]   w_gnext;
  logic                w_wend;

  logic                r_v1, r_v2, r_pd_valid;
  logic signed [16:0]  r_e1, r_e2;
  logic [16:0]         r_amp1;
  logic                r_good2, r_good3;
  logic signed [25:0]  r_pd;
  logic [WIN_LOG2-1:0] r_wcnt;
  logic [WIN_LOG2:0]   r_gcnt;
  logic [WIN_LOG2:0]   r_lock_metric;
  logic                r_locked;
  state_t              r_state;

  // Error terms in 18 bits so negating -32768 cannot overflow before the final 17-bit slice.
  always_comb begin
    w_i18   = {{2{s.di[15]}}, s.di};
    w_q18   = {{2{s.dq[15]}}, s.dq};
    w_neg_i = 18'sd0 - w_i18;
    w_neg_q = 18'sd0 - w_q18;
    w_t1    = s.di[15] ? w_neg_q : w_q18;
    w_t2    = s.dq[15] ? w_neg_i : w_i18;
    w_e18   = w_t1 - w_t2;
    w_abs_i = s.di[15] ? w_neg_i[16:0] : w_i18[16:0];
    w_abs_q = s.dq[15] ? w_neg_q[16:0] : w_q18[16:0];
    w_amp   = w_abs_i + w_abs_q;
  end

  // Goodness test on stage-1 results and pd scaling of the stage-2 error.
  always_comb begin
    w_neg_e  = 17'sd0 - r_e1;
    w_abs_e  = r_e1[16] ? w_neg_e : r_e1;
    w_tol    = r_amp1 >> LOCK_SHIFT;
    w_good   = (w_abs_e <= w_tol) && (r_amp1 >= MIN_AMP_C);
    w_pd_ext = {{9{r_e2[16]}}, r_e2} <<< PD_SHIFT;
    w_gnext  = r_gcnt + {{WIN_LOG2{1'b0}}, r_good3};
    w_wend   = &r_wcnt;
  end

  // Two-stage datapath; payload registers only move with their valid bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1       <= 1'b0;
      r_v2       <= 1'b0;
      r_pd_valid <= 1'b0;
      r_e1       <= 17'sd0;
      r_amp1     <= 17'd0;
      r_e2       <= 17'sd0;
      r_good2    <= 1'b0;
      r_good3    <= 1'b0;
      r_pd       <= 26'sd0;
    end else begin
      r_v1       <= s.din_valid;
      r_v2       <= r_v1;
      r_pd_valid <= r_v2;
      if (s.din_valid) begin
        r_e1   <= w_e18[16:0];
        r_amp1 <= w_amp;
      end
      if (r_v1) begin
        r_e2    <= r_e1;
        r_good2 <= w_good;
      end
      if (r_v2) begin
        r_pd    <= w_pd_ext;
        r_good3 <= r_good2;
      end
    end
  end

  // Window counting and lock FSM, evaluated on the edge after each pd strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wcnt        <= {WIN_LOG2{1'b0}};
      r_gcnt        <= {(WIN_LOG2+1){1'b0}};
      r_lock_metric <= {(WIN_LOG2+1){1'b0}};
      r_locked      <= 1'b0;
      r_state       <= ST_UNLOCKED;
    end else if (r_pd_valid) begin
      r_wcnt <= r_wcnt + WCNT_ONE;
      if (w_wend) begin
        r_gcnt        <= {(WIN_LOG2+1){1'b0}};
        r_lock_metric <= w_gnext;
        case (r_state)
          ST_UNLOCKED: begin
            r_state  <= (w_gnext >= LOCK_TH_C) ? ST_CANDIDATE : ST_UNLOCKED;
            r_locked <= 1'b0;
          end
          ST_CANDIDATE: begin
            r_state  <= (w_gnext >= LOCK_TH_C) ? ST_LOCKED : ST_UNLOCKED;
            r_locked <= (w_gnext >= LOCK_TH_C);
          end
          ST_LOCKED: begin
            r_state  <= (w_gnext < UNLOCK_TH_C) ? ST_UNLOCKED : ST_LOCKED;
            r_locked <= !(w_gnext < UNLOCK_TH_C);
          end
          default: begin
            r_state  <= ST_UNLOCKED;
            r_locked <= 1'b0;
          end
        endcase
      end else begin
        r_gcnt <= w_gnext;
      end
    end
  end

  assign s.pd          = r_pd;
  assign s.pd_valid    = r_pd_valid;
  assign s.locked      = r_locked;
  assign s.lock_metric = r_lock_metric;

endmodule

// File: tb/tb_carrier_phase_detector.sv
// Directed-vector bench for carrier_phase_detector: pd values and latency, window
// metrics, lock hysteresis and mid-window reset behaviour.
module tb_carrier_phase_detector;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;
  int   seen;

  carrier_phase_detector_if #(.WIN_LOG2(8)) u_if ();

  carrier_phase_detector #(
    .PD_SHIFT(8), .WIN_LOG2(8), .LOCK_TH(224), .UNLOCK_TH(160),
    .LOCK_SHIFT(2), .MIN_AMP(256)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .s   (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input longint obs, input longint exp_v);
    n_vec++;
    if (obs != exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
    end
  endtask

  // One isolated sample: checks latency, value, hold, and that idle di/dq are ignored.
  task automatic send_one(input string tag, input logic signed [15:0] i_v,
                          input logic signed [15:0] q_v, input longint exp_pd);
    u_if.din_valid = 1'b1;
    u_if.di        = i_v;
    u_if.dq        = q_v;
    @(posedge clk); #1;
    u_if.din_valid = 1'b0;
    u_if.di        = 16'sh1234;
    u_if.dq        = -16'sd4321;
    @(posedge clk); #1;
    check_val({tag, "_early_valid"}, longint'(u_if.pd_valid), 64'sd0);
    @(posedge clk); #1;
    check_val({tag, "_valid"}, longint'(u_if.pd_valid), 64'sd1);
    check_val({tag, "_pd"}, longint'(u_if.pd), exp_pd);
    @(posedge clk); #1;
    check_val({tag, "_strobe_len"}, longint'(u_if.pd_valid), 64'sd0);
    check_val({tag, "_pd_hold"}, longint'(u_if.pd), exp_pd);
  endtask

  task automatic stream(input int n, input logic signed [15:0] i_v,
                        input logic signed [15:0] q_v);
    u_if.din_valid = 1'b1;
    u_if.di        = i_v;
    u_if.dq        = q_v;
    repeat (n) @(posedge clk);
    #1;
    u_if.din_valid = 1'b0;
  endtask

  // Called right after the window's last sample is accepted.
  task automatic finish_window(input string tag, input longint exp_metric,
                               input longint lk_before, input longint lk_after);
    @(posedge clk);
    @(posedge clk); #1;
    check_val({tag, "_last_valid"}, longint'(u_if.pd_valid), 64'sd1);
    check_val({tag, "_locked_before"}, longint'(u_if.locked), lk_before);
    @(posedge clk); #1;
    check_val({tag, "_locked_after"}, longint'(u_if.locked), lk_after);
    check_val({tag, "_metric"}, longint'(u_if.lock_metric), exp_metric);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    u_if.din_valid = 1'b0;
    u_if.di = 16'sd0;
    u_if.dq = 16'sd0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_pd", longint'(u_if.pd), 64'sd0);
    check_val("rst_pd_valid", longint'(u_if.pd_valid), 64'sd0);
    check_val("rst_locked", longint'(u_if.locked), 64'sd0);
    check_val("rst_metric", longint'(u_if.lock_metric), 64'sd0);
    rst = 1'b0;

    // Window 1: good, bad, good, good, bad(low amp), then 251 bad -> metric 3.
    send_one("s_1000_1000", 16'sd1000, 16'sd1000, 64'sd0);
    send_one("s_1000_0", 16'sd1000, 16'sd0, -64'sd256000);
    send_one("s_min_max", 16'sh8000, 16'sh7FFF, 64'sd256);
    send_one("s_min_min", 16'sh8000, 16'sh8000, 64'sd0);
    send_one("s_zero", 16'sd0, 16'sd0, 64'sd0);
    stream(251, 16'sd1000, 16'sd0);
    finish_window("w1", 64'sd3, 64'sd0, 64'sd0);

    // Two full-good windows: CANDIDATE then LOCKED.
    stream(256, 16'sd1000, 16'sd1000);
    finish_window("w2", 64'sd256, 64'sd0, 64'sd0);
    stream(256, 16'sd1000, 16'sd1000);
    finish_window("w3", 64'sd256, 64'sd0, 64'sd1);

    // 200 good keeps lock; 0 good drops it.
    stream(200, 16'sd1000, 16'sd1000);
    stream(56, 16'sd1000, 16'sd0);
    finish_window("w4", 64'sd200, 64'sd1, 64'sd1);
    stream(256, 16'sd1000, 16'sd0);
    finish_window("w5", 64'sd0, 64'sd1, 64'sd0);

    stream(256, 16'sd1000, 16'sd1000);
    finish_window("w6", 64'sd256, 64'sd0, 64'sd0);
    stream(256, 16'sd1000, 16'sd1000);
    finish_window("w7", 64'sd256, 64'sd0, 64'sd1);

    // Alternating valid for 100 samples, then reset with a sample in flight.
    for (int k = 0; k < 100; k++) begin
      u_if.din_valid = 1'b1;
      u_if.di = 16'sd1000;
      u_if.dq = 16'sd0;
      @(posedge clk); #1;
      u_if.din_valid = 1'b0;
      @(posedge clk); #1;
    end
    check_val("pre_rst_locked", longint'(u_if.locked), 64'sd1);
    check_val("pre_rst_pd", longint'(u_if.pd), -64'sd256000);
    rst = 1'b1;
    #1;
    check_val("mid_rst_pd", longint'(u_if.pd), 64'sd0);
    check_val("mid_rst_pd_valid", longint'(u_if.pd_valid), 64'sd0);
    check_val("mid_rst_locked", longint'(u_if.locked), 64'sd0);
    check_val("mid_rst_metric", longint'(u_if.lock_metric), 64'sd0);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (u_if.pd_valid) seen++;
    end
    check_val("no_stale_valid", longint'(seen), 64'sd0);

    // Window restarts at the first post-reset sample: nothing completes after 255.
    stream(255, 16'sd1000, 16'sd1000);
    repeat (4) @(posedge clk);
    #1;
    check_val("post_rst_255_metric", longint'(u_if.lock_metric), 64'sd0);
    stream(1, 16'sd1000, 16'sd1000);
    finish_window("post_rst", 64'sd256, 64'sd0, 64'sd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/carrier_phase_detector.md
CARRIER_PHASE_DETECTOR -- requirements
Module: carrier_phase_detector

Interface
REQ-001 SHALL have parameter PD_SHIFT, default 8, meaning left shift applied to the raw error before output; legal range 0..9.
REQ-002 SHALL have parameter WIN_LOG2, default 8, meaning log2 of the lock-evaluation window length in valid samples (WIN = 2^WIN_LOG2).
REQ-003 SHALL have parameter LOCK_TH, default 224, meaning the minimum good-sample count for a window to pass.
REQ-004 SHALL have parameter UNLOCK_TH, default 160, meaning that a LOCKED-state window below this count fails.
REQ-005 SHALL have parameter LOCK_SHIFT, default 2, meaning the right shift of |I|+|Q| used as the error tolerance.
REQ-006 SHALL have parameter MIN_AMP, default 256, meaning the minimum |I|+|Q| for a sample to count as good.
REQ-007 SHALL have port clk, input, 1 bit, meaning the system clock (8 MHz).
REQ-008 SHALL have port rst, input, 1 bit, meaning reset, asynchronous, active-high.
REQ-009 SHALL have port din_valid, input, 1 bit, meaning di/dq carry a sample this cycle.
REQ-010 SHALL have port di, input, signed 16 bits, meaning the baseband I sample.
REQ-011 SHALL have port dq, input, signed 16 bits, meaning the baseband Q sample.
REQ-012 SHALL have port pd, output, signed 26 bits, meaning the phase error, held between updates; this port feeds the loop filter's pd input.
REQ-013 SHALL have port pd_valid, output, 1 bit, meaning a one-cycle strobe on each pd update.
REQ-014 SHALL have port locked, output, 1 bit, meaning the carrier lock indicator.
REQ-015 SHALL have port lock_metric, output, unsigned WIN_LOG2+1 bits, meaning the good-sample count of the last completed window.

Function
REQ-016 SHALL define sign(x) as +1 for x>=0 and -1 for x<0.
REQ-017 SHALL compute the raw error e = sign(I)*Q - sign(Q)*I, exactly, in 17-bit signed arithmetic; the range is -32768..+32768, with no overflow for any input including -32768.
REQ-018 SHALL produce pd = sign-extend(e) << PD_SHIFT, which fits 26 bits for every legal PD_SHIFT, with no saturation required.
REQ-019 SHALL use a two-stage pipeline: a sample accepted at edge k drives pd and pd_valid at edge k+2.
REQ-020 SHALL leave pd unchanged and pd_valid low when no sample is accepted; bubbles in din_valid propagate as bubbles with no reordering.
REQ-021 SHALL ignore di and dq when din_valid is low.
REQ-022 SHALL mark a sample good when |e| <= ((|I|+|Q|) >> LOCK_SHIFT) and (|I|+|Q|) >= MIN_AMP, where |I|+|Q| is computed in 17 bits unsigned.
REQ-023 SHALL have window counter wcnt (WIN_LOG2 bits) advance once per stage-2 valid sample and wrap from WIN-1 to 0.
REQ-024 SHALL have good counter gcnt (WIN_LOG2+1 bits) increment on each good stage-2 sample; it reaches WIN with no wrap.
REQ-025 SHALL treat the stage-2 sample at wcnt = WIN-1 as window end, and the final count SHALL include that sample.
REQ-026 SHALL, at window end, load lock_metric with the final count, clear gcnt to 0 (the next window starts clean), and evaluate the FSM; locked and lock_metric update one edge after the window-end sample's pd_valid edge.
REQ-027 SHALL implement FSM states UNLOCKED, CANDIDATE and LOCKED, with locked high only in LOCKED.
REQ-028 SHALL have UNLOCKED go to CANDIDATE when count >= LOCK_TH, and otherwise stay in UNLOCKED.
REQ-029 SHALL have CANDIDATE go to LOCKED when count >= LOCK_TH, and otherwise go to UNLOCKED.
REQ-030 SHALL have LOCKED go to UNLOCKED when count < UNLOCK_TH, and otherwise stay in LOCKED (hysteresis).
REQ-031 SHALL change the FSM state only at window end.

Reset
REQ-032 SHALL, on rst high, immediately clear pd to 0, pd_valid to 0, locked to 0, lock_metric to 0, wcnt to 0, gcnt to 0, the pipeline valid bits to 0, and the FSM to UNLOCKED.
REQ-033 SHALL discard in-flight samples on rst mid-window, with no pd_valid after release for samples accepted before reset; the first window after release starts at wcnt=0.

Verification
REQ-034 SHALL pass this scenario: di=1000, dq=1000 with din_valid high -> pd=0, pd_valid high two edges after the sample, and the sample counts as good.
REQ-035 SHALL pass this scenario: di=1000, dq=0 -> e=-1000 and pd=-256000, and the sample is not good (1000 > 250).
REQ-036 SHALL pass this scenario: di=-32768, dq=32767 -> pd=256; di=-32768, dq=-32768 -> pd=0; di=0, dq=0 -> pd=0, and the sample is not good (below MIN_AMP).
REQ-037 SHALL pass this scenario: 512 consecutive valid samples of (1000,1000) -> lock_metric=256 after sample 256 with the FSM in CANDIDATE, and locked rises one edge after sample 512's pd_valid.
REQ-038 SHALL pass this scenario: after lock, 256 samples of (1000,0) -> lock_metric=0 and locked falls at window end; a window of 200 good samples while LOCKED keeps locked high.
REQ-039 SHALL pass this scenario: din_valid toggling every other cycle plus rst asserted after 100 samples of a window -> outputs are zero at once, and window timing restarts from the first valid sample after release.
